// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the float-to-integer conversion path.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  localparam logic [31:0] INT_MAX    = 32'h7fffffff;
  localparam logic [31:0] INT_MIN    = 32'h80000000;
  localparam logic [31:0] FP_INT_MIN = 32'hcf000000;

  // Exponent thresholds: >= 2^31 saturates, < 0.5 flushes, 2^23 needs no shift
  localparam logic [7:0] EXP_SAT  = 8'(FP_BIAS + 31);
  localparam logic [7:0] EXP_HALF = 8'(FP_BIAS - 1);
  localparam logic [7:0] EXP_INT  = 8'(FP_BIAS + 23);

  typedef enum logic [1:0] {ZERO, SAT, MINEXACT, NORMAL} ftoi_class_t;

endpackage

// File: rtl/ftoi_round_shift.sv
// Normal-path magnitude: shift mantissa into integer position, round half away, apply sign.
module ftoi_round_shift
  import fpu_pkg::*;
(
  input  logic [23:0] m,
  input  logic [7:0]  e,
  input  logic        s,
  output logic [31:0] result
);

  logic [31:0] mag;
  logic [24:0] half;

  // half keeps one extra bit below the integer point; that bit is the rounding increment
  always_comb begin
    half = {m, 1'b0} >> (EXP_INT - e);
    if (e >= EXP_INT) begin
      mag = {8'b0, m} << (e - EXP_INT);
    end else begin
      mag = {8'b0, half[24:1]} + {31'b0, half[0]};
    end
    result = s ? -mag : mag;
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float-to-int converter: S1 decodes and classifies, S2 holds the result.
module ftoi_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;
  ftoi_class_t s1_class;

  ftoi_class_t in_class;
  logic [7:0]  in_exp;
  logic        adv1;
  logic        adv2;
  logic [31:0] norm_result;
  logic [31:0] s2_next;

  assign in_exp = in_data[EXP_MSB:EXP_LSB];

  // -2^31 is the one float at the saturating exponent that is exactly representable
  always_comb begin
    in_class = NORMAL;
    if (in_data == FP_INT_MIN) begin
      in_class = MINEXACT;
    end else if (in_exp >= EXP_SAT) begin
      in_class = SAT;
    end else if (in_exp < EXP_HALF) begin
      in_class = ZERO;
    end
  end

  always_comb begin
    adv2     = !out_valid || out_ready;
    adv1     = !s1_valid || adv2;
    in_ready = adv1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_data[SIGN_BIT];
        s1_exp   <= in_exp;
        s1_mant  <= {1'b1, in_data[FRAC_MSB:FRAC_LSB]};
        s1_class <= in_class;
      end
    end
  end

  ftoi_round_shift u_round_shift (
    .m      (s1_mant),
    .e      (s1_exp),
    .s      (s1_sign),
    .result (norm_result)
  );

  always_comb begin
    s2_next = norm_result;
    case (s1_class)
      MINEXACT: s2_next = INT_MIN;
      SAT:      s2_next = s1_sign ? INT_MIN : INT_MAX;
      ZERO:     s2_next = 32'd0;
      default:  s2_next = norm_result;
    endcase
  end

  // out_data only changes when a new result lands, so it holds through stalls and bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: vector table, handshake corner cases, random stream vs model.
module tb_ftoi_pipe;

  localparam int NRAND = 20000;

  typedef struct {
    logic [31:0] data;
    logic [31:0] want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int          checks = 0;
  int          errors = 0;
  bit          use_model;
  logic [31:0] cur_exp;
  logic [31:0] exp_q[$];
  vec_t        tbl[12];
  logic [31:0] bp_data[3];

  ftoi_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: exact value m * 2^(e-150) rounded half away, then clamped to int32
  function automatic logic [31:0] ref_ftoi(input logic [31:0] f);
    int     e;
    longint m;
    longint mag;
    longint v;
    int     k;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e == 255 || e > 180) return f[31] ? 32'h80000000 : 32'h7fffffff;
    if (e < 126) return 32'd0;
    if (e >= 150) begin
      mag = m << (e - 150);
    end else begin
      k   = 150 - e;
      mag = (m + (64'sd1 <<< (k - 1))) >>> k;
    end
    v = f[31] ? -mag : mag;
    if (v > 64'sd2147483647) return 32'h7fffffff;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom();
    case ($urandom_range(0, 3))
      1: f[30:23] = 8'($urandom_range(120, 160));
      2: begin
        f[30:23] = 8'($urandom_range(125, 151));
        if ($urandom_range(0, 1) == 1) f[22:0] = 23'h400000 >> $urandom_range(0, 22);
      end
      3: case ($urandom_range(0, 3))
        0:       f = 32'hcf000000;
        1:       f[30:23] = 8'd158;
        2:       f[30:23] = 8'd255;
        default: f[30:23] = 8'd0;
      endcase
      default: ;
    endcase
    return f;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic [31:0] want);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    cur_exp  = want;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: expected values queued at accept, compared in order at each pop
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(use_model ? ref_ftoi(in_data) : cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stale_output got %h want none", out_data);
        end else begin
          check_output("result", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_acc;
    int idx;
    int cyc;

    tbl[0]  = '{32'h3fc00000, 32'h00000002};
    tbl[1]  = '{32'hc0200000, 32'hfffffffd};
    tbl[2]  = '{32'h3effffff, 32'h00000000};
    tbl[3]  = '{32'h3f000000, 32'h00000001};
    tbl[4]  = '{32'h4effffff, 32'h7fffff80};
    tbl[5]  = '{32'h4f000000, 32'h7fffffff};
    tbl[6]  = '{32'hcf000000, 32'h80000000};
    tbl[7]  = '{32'hcf000001, 32'h80000000};
    tbl[8]  = '{32'h7fc00000, 32'h7fffffff};
    tbl[9]  = '{32'h00000001, 32'h00000000};
    tbl[10] = '{32'h80000000, 32'h00000000};
    tbl[11] = '{32'h007fffff, 32'h00000000};
    bp_data[0] = 32'h40400000;
    bp_data[1] = 32'h40800000;
    bp_data[2] = 32'h40a00000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    use_model = 1'b0;
    cur_exp   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_data", out_data, 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);

    // Table vectors streamed back to back with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) apply_stimulus(tbl[i].data, tbl[i].want);
    repeat (4) @(posedge clk);
    #1;
    check_output("table_drain", 32'(exp_q.size()), 32'd0);

    // Latency: operand presented after edge N is visible after edge N+2
    use_model = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3fc00000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("latency_n1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("latency_n2", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two operands fit, then the pipe holds 3 until released
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx       = 0;
    n_acc     = 0;
    in_data   = bp_data[0];
    for (int c = 0; c < 16 && idx < 3; c++) begin
      if (c == 6) begin
        check_output("bp_accepted", 32'(n_acc), 32'd2);
        check_output("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (c >= 3 && c < 6) begin
        check_output("bp_hold_valid", 32'(out_valid), 32'd1);
        check_output("bp_hold_data", out_data, 32'h00000003);
      end
      if (in_ready) n_acc++;
      @(posedge clk);
      #1;
      if (n_acc > idx) begin
        idx = n_acc;
        if (idx < 3) in_data = bp_data[idx];
      end
    end
    in_valid = 1'b0;
    check_output("bp_all_accepted", 32'(idx), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check_output("bp_drain", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full: nothing in flight may surface afterwards
    out_ready = 1'b0;
    apply_stimulus(32'h40000000, 32'd0);
    apply_stimulus(32'h40e00000, 32'd0);
    check_output("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the reference model
    n_acc = 0;
    cyc   = 0;
    while (n_acc < NRAND && cyc < 80000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_float();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("rand_count", 32'(n_acc), 32'(NRAND));
    check_output("rand_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
